// File: rtl/bc_pkg.sv
// bc_pkg: state encoding and datapath select codes shared by the bc_polinomio control block.
package bc_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LDX  = 3'd2,
        ST_A = 3'd3,
        ST_B = 3'd4,
        ST_C = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_C    = 2'd2;

    localparam logic [1:0] SEL_ZERO = 2'd0;
    localparam logic [1:0] SEL_H    = 2'd1;
    localparam logic [1:0] SEL_X    = 2'd2;

    localparam logic [1:0] SEL_XM   = 2'd0;
    localparam logic [1:0] SEL_ONE  = 2'd1;

endpackage

// File: rtl/bc_step_timer.sv
// bc_step_timer: settle counter for one arithmetic step; tc flags the cycle where count equals MUL_WAIT.
module bc_step_timer #(
    parameter int MUL_WAIT = 0,
    parameter int CW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    output logic [CW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= clr ? '0 : count + 1'b1;
    end

    assign tc = count == CW'(MUL_WAIT);

endmodule

// File: rtl/bc_polinomio.sv
// bc_polinomio: Horner sequencer driving BO to compute S = A*x^2 + B*x + C on the shared SomaMultiplica.
// Optional BC_EVAL_COUNT_EN adds eval_cnt, a wrapping count of completed (non-aborted) evaluations.
module bc_polinomio
    import bc_pkg::*;
#(
    parameter int MUL_WAIT = 0,
    parameter int CW       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic        LX,
    output logic        RSTX,
    output logic [1:0]  M0,
    output logic [1:0]  M1,
    output logic [1:0]  M2,
    output logic        LH,
    output logic        RSTH,
    output logic        LS,
    output logic        busy,
    output logic        done
`ifdef BC_EVAL_COUNT_EN
   ,output logic [15:0] eval_cnt
`endif
);

    state_t        state;
    logic [CW-1:0] count;
    logic          tc;
    logic          inStep;
    logic          aborting;
    logic          strobe;

    assign inStep = state inside {ST_A, ST_B, ST_C};

    bc_step_timer #(.MUL_WAIT(MUL_WAIT), .CW(CW)) stepTimer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (aborting | tc | !inStep),
        .count (count),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        state <= IDLE;
        else if (aborting) state <= IDLE;
        else begin
            case (state)
                IDLE:    state <= start ? CLR : IDLE;
                CLR:     state <= LDX;
                LDX:     state <= ST_A;
                ST_A:    state <= tc ? ST_B : ST_A;
                ST_B:    state <= tc ? ST_C : ST_B;
                ST_C:    state <= tc ? DONE : ST_C;
                default: state <= IDLE;
            endcase
        end
    end

    // abort overrides the step's load strobe and the done pulse in the same cycle
    always_comb begin
        busy     = state != IDLE;
        aborting = busy & abort;
        strobe   = tc & inStep & !aborting;
        LX       = state == LDX;
        RSTX     = state == CLR;
        RSTH     = state == CLR || aborting;
        M0       = state == ST_B ? SEL_B : state == ST_C ? SEL_C : SEL_A;
        M1       = state inside {ST_B, ST_C} ? SEL_H : SEL_ZERO;
        M2       = SEL_XM;
        LH       = strobe && state != ST_C;
        LS       = strobe && state == ST_C;
        done     = state == DONE && !aborting;
    end

`ifdef BC_EVAL_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    eval_cnt <= '0;
        else if (done) eval_cnt <= eval_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_bc_polinomio.sv
// tb_bc_polinomio: two instances (MUL_WAIT 0 and 2) checked cycle by cycle against a schedule model
// and a behavioural BO that must hold A*x^2+B*x+C at every done pulse.
module tb_bc_polinomio;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    always #5 clk = ~clk;

    logic       lx[2], rstx[2], lh[2], rsth[2], ls[2], busy[2], done[2];
    logic [1:0] m0[2], m1[2], m2[2];
`ifdef BC_EVAL_COUNT_EN
    logic [15:0] evalCnt[2];
`endif

    bc_polinomio #(.MUL_WAIT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .LX(lx[0]), .RSTX(rstx[0]), .M0(m0[0]), .M1(m1[0]), .M2(m2[0]),
        .LH(lh[0]), .RSTH(rsth[0]), .LS(ls[0]), .busy(busy[0]), .done(done[0])
`ifdef BC_EVAL_COUNT_EN
       ,.eval_cnt(evalCnt[0])
`endif
    );

    bc_polinomio #(.MUL_WAIT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .LX(lx[1]), .RSTX(rstx[1]), .M0(m0[1]), .M1(m1[1]), .M2(m2[1]),
        .LH(lh[1]), .RSTH(rsth[1]), .LS(ls[1]), .busy(busy[1]), .done(done[1])
`ifdef BC_EVAL_COUNT_EN
       ,.eval_cnt(evalCnt[1])
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // model: pos = cycles since CLR (-1 when idle); BO registers and done counts per instance
    int          waitOf[2] = '{0, 2};
    int          pos[2] = '{-1, -1};
    int          dones[2] = '{0, 0};
    bit   [15:0] cntModel[2] = '{16'd0, 16'd0};
    bit   [15:0] xr[2] = '{16'd0, 16'd0};
    bit   [15:0] hr[2] = '{16'd0, 16'd0};
    bit   [15:0] sr[2] = '{16'd0, 16'd0};
    bit   [15:0] a, b, c, x;

    // packed {LX,RSTX,M0,M1,M2,LH,RSTH,LS,busy,done}
    function automatic logic [12:0] obsOf(input int i);
        return {lx[i], rstx[i], m0[i], m1[i], m2[i], lh[i], rsth[i], ls[i], busy[i], done[i]};
    endfunction

    function automatic logic [12:0] expOut(input int p, input int w, input bit ab);
        logic eLx = 0, eRstx = 0, eLh = 0, eRsth = 0, eLs = 0, eDone = 0;
        logic [1:0] eM0 = 0, eM1 = 0;
        int last = 2 + 3 * (w + 1);
        int k, sub;
        if (p < 0) return '0;
        eRsth = ab;
        if (p == 0) begin
            eRstx = 1; eRsth = 1;
        end else if (p == 1) begin
            eLx = 1;
        end else if (p < last) begin
            k = (p - 2) / (w + 1);
            sub = (p - 2) % (w + 1);
            eM0 = 2'(k);
            eM1 = (k == 0) ? 2'd0 : 2'd1;
            eLh = (sub == w) && !ab && k < 2;
            eLs = (sub == w) && !ab && k == 2;
        end else begin
            eDone = !ab;
        end
        return {eLx, eRstx, eM0, eM1, 2'd0, eLh, eRsth, eLs, 1'b1, eDone};
    endfunction

    task automatic cycle(input bit st, input bit ab);
        logic [12:0] got[2];
        logic [12:0] e;
        bit   [15:0] m0op, m1op, m2op, saida;
        @(negedge clk);
        start = st;
        abort = ab;
        #1;
        for (int i = 0; i < 2; i++) begin
            got[i] = obsOf(i);
            e = expOut(pos[i], waitOf[i], ab);
            check($sformatf("ctl_w%0d_p%0d", waitOf[i], pos[i]), got[i], e);
`ifdef BC_EVAL_COUNT_EN
            check($sformatf("evalcnt_w%0d", waitOf[i]), evalCnt[i], cntModel[i]);
`endif
            if (e[0]) begin
                dones[i]++;
                cntModel[i]++;
                check($sformatf("pronto_w%0d", waitOf[i]), sr[i], a * x * x + b * x + c);
            end
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m0op  = got[i][10:9] == 2'd0 ? a : got[i][10:9] == 2'd1 ? b : c;
            m1op  = got[i][8:7] == 2'd0 ? 16'd0 : got[i][8:7] == 2'd1 ? hr[i] : xr[i];
            m2op  = got[i][6:5] == 2'd0 ? xr[i] : 16'd1;
            saida = m1op * m2op + m0op;
            xr[i] = got[i][11] ? 16'd0 : got[i][12] ? x : xr[i];
            hr[i] = got[i][3] ? 16'd0 : got[i][4] ? saida : hr[i];
            sr[i] = got[i][2] ? saida : sr[i];
            if (pos[i] < 0) pos[i] = st ? 0 : -1;
            else if (ab || pos[i] == 2 + 3 * (waitOf[i] + 1)) pos[i] = -1;
            else pos[i]++;
        end
    endtask

    int d0, d1;

    initial begin
        a = 0; b = 0; c = 0; x = 0;
        #12;
        check("reset_out0", obsOf(0), 13'd0);
        check("reset_out2", obsOf(1), 13'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0);

        // A=2 B=3 C=4 x=5 -> 69
        a = 2; b = 3; c = 4; x = 5;
        cycle(1, 0);
        repeat (14) cycle(0, 0);
        check("basic_pronto0", sr[0], 16'd69);
        check("basic_pronto2", sr[1], 16'd69);

        // A=1 B=0 C=7 x=3 -> 16
        a = 1; b = 0; c = 7; x = 3;
        d0 = dones[0]; d1 = dones[1];
        cycle(1, 0);
        repeat (3) cycle(0, 0);
        cycle(1, 0);
        repeat (12) cycle(0, 0);
        check("settle_pronto2", sr[1], 16'd16);
        check("ignored_start0", dones[0] - d0, 1);
        check("ignored_start2", dones[1] - d1, 1);

        // abort on the ST_C terminal-count cycle of the MUL_WAIT=0 instance
        a = 3; b = 1; c = 2; x = 4;
        d0 = dones[0]; d1 = dones[1];
        cycle(1, 0);
        repeat (4) cycle(0, 0);
        cycle(0, 1);
        repeat (3) cycle(0, 0);
        check("abort_nodone0", dones[0] - d0, 0);
        check("abort_nodone2", dones[1] - d1, 0);
        check("abort_pronto0", sr[0], 16'd16);

        // asynchronous reset mid-evaluation
        cycle(1, 0);
        repeat (3) cycle(0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_out0", obsOf(0), 13'd0);
        check("midreset_out2", obsOf(1), 13'd0);
        pos = '{-1, -1};
        cntModel = '{16'd0, 16'd0};
        @(negedge clk);
        rst_n = 1'b1;

        // start held high: back-to-back runs 7 cycles apart
        a = 4; b = 5; c = 6; x = 7;
        d0 = dones[0];
        repeat (24) cycle(1, 0);
        repeat (2) cycle(0, 0);
        check("b2b_dones0", dones[0] - d0, 3);
`ifdef BC_EVAL_COUNT_EN
        check("b2b_evalcnt0", evalCnt[0], 16'd3);
`endif
        repeat (20) cycle(0, 0);

        for (int n = 0; n < 3000; n++) begin
            if (pos[0] < 0 && pos[1] < 0) begin
                a = 16'($urandom_range(0, 15));
                b = 16'($urandom_range(0, 15));
                c = 16'($urandom_range(0, 15));
                x = 16'($urandom_range(0, 15));
            end
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
